// File: rtl/tiny_alu_arbiter_if.sv
// Requester-side and ALU-side signals of the shared tiny ALU arbiter.
// slave = the arbiter, master = whatever drives requests and models the ALU.
interface tiny_alu_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int INPUT_DATA_BITS = 8,
    parameter int OPCODE_BITS     = 3
);
    logic [NUM_REQ-1:0]                         req_valid_i;
    logic [NUM_REQ-1:0][INPUT_DATA_BITS-1:0]    req_a_i;
    logic [NUM_REQ-1:0][INPUT_DATA_BITS-1:0]    req_b_i;
    logic [NUM_REQ-1:0][OPCODE_BITS-1:0]        req_opcode_i;
    logic [NUM_REQ-1:0]                         req_ready_o;
    logic [NUM_REQ-1:0]                         rsp_valid_o;
    logic [2*INPUT_DATA_BITS-1:0]               rsp_result_o;
    logic                                       rsp_err_o;
    logic [INPUT_DATA_BITS-1:0]                 alu_a_o;
    logic [INPUT_DATA_BITS-1:0]                 alu_b_o;
    logic [OPCODE_BITS-1:0]                     alu_opcode_o;
    logic                                       alu_start_o;
    logic [2*INPUT_DATA_BITS-1:0]               alu_result_i;
    logic                                       alu_done_i;
    logic                                       busy_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_opcode_i, alu_result_i, alu_done_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
               alu_a_o, alu_b_o, alu_opcode_o, alu_start_o, busy_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_opcode_i, alu_result_i, alu_done_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o,
               alu_a_o, alu_b_o, alu_opcode_o, alu_start_o, busy_o
    );
endinterface

// File: rtl/tiny_alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU among NUM_REQ requesters,
// with a BUSY timeout and a one-cycle one-hot response pulse per operation.
module tiny_alu_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int INPUT_DATA_BITS = 8,
    parameter int OPCODE_BITS     = 3,
    parameter int TIMEOUT         = 16
) (
    input logic              clk_i,
    input logic              reset_i,
    tiny_alu_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int DW    = INPUT_DATA_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         lat_idx;
    logic [DW-1:0]            lat_a;
    logic [DW-1:0]            lat_b;
    logic [OPCODE_BITS-1:0]   lat_op;
    logic [CNT_W-1:0]         tmo_cnt;
    logic [2*DW-1:0]          rsp_result;
    logic                     rsp_err;
    logic                     alu_start;
    logic [NUM_REQ-1:0]       rsp_vld;

    logic [IDX_W-1:0]         gnt_idx;
    logic [IDX_W-1:0]         cand;
    logic                     gnt_found;
    logic [OPCODE_BITS-1:0]   gnt_op;
    logic                     tmo_hit;
    logic                     rsp_fire;
    logic [IDX_W-1:0]         rsp_idx;
    logic [IDX_W-1:0]         rr_next;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s -= NUM_REQ;
        return IDX_W'(s);
    endfunction

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_idx(rr_ptr, i);
            if (!gnt_found && bus.req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign gnt_op  = bus.req_opcode_i[gnt_idx];
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign rr_next = (lat_idx == IDX_W'(NUM_REQ - 1)) ? '0 : lat_idx + IDX_W'(1);

    // A no-op transfer responds straight from IDLE, before lat_idx is loaded.
    assign rsp_fire = ((state == IDLE) && gnt_found && (gnt_op == '0)) ||
                      ((state == BUSY) && (bus.alu_done_i || tmo_hit));
    assign rsp_idx  = (state == IDLE) ? gnt_idx : lat_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign bus.req_ready_o[g] = (state == IDLE) && gnt_found && (gnt_idx == IDX_W'(g));

        always_ff @(posedge clk_i) begin
            if (reset_i) rsp_vld[g] <= 1'b0;
            else         rsp_vld[g] <= rsp_fire && (rsp_idx == IDX_W'(g));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lat_idx    <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            tmo_cnt    <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            alu_start  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (gnt_found) begin
                        lat_idx <= gnt_idx;
                        lat_a   <= bus.req_a_i[gnt_idx];
                        lat_b   <= bus.req_b_i[gnt_idx];
                        lat_op  <= gnt_op;
                        if (gnt_op != '0) begin
                            state     <= BUSY;
                            alu_start <= 1'b1;
                        end else begin
                            state      <= RESP;
                            rsp_result <= '0;
                            rsp_err    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    // done has priority over an expiring counter
                    if (bus.alu_done_i) begin
                        state      <= RESP;
                        alu_start  <= 1'b0;
                        rsp_result <= bus.alu_result_i;
                        rsp_err    <= 1'b0;
                    end else if (tmo_hit) begin
                        state      <= RESP;
                        alu_start  <= 1'b0;
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    rr_ptr  <= rr_next;
                    tmo_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid_o  = rsp_vld;
    assign bus.rsp_result_o = rsp_result;
    assign bus.rsp_err_o    = rsp_err;
    assign bus.alu_a_o      = lat_a;
    assign bus.alu_b_o      = lat_b;
    assign bus.alu_opcode_o = lat_op;
    assign bus.alu_start_o  = alu_start;
    assign bus.busy_o       = (state != IDLE);

endmodule

// File: tb/tb_tiny_alu_arbiter.sv
// Directed bench for tiny_alu_arbiter: single op, fairness, no-op,
// done/timeout tie, reset mid-operation with stale done, and timeout.
module tb_tiny_alu_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    tiny_alu_arbiter_if #(.NUM_REQ(4), .INPUT_DATA_BITS(8), .OPCODE_BITS(3)) bus ();

    tiny_alu_arbiter #(.NUM_REQ(4), .INPUT_DATA_BITS(8), .OPCODE_BITS(3), .TIMEOUT(16)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: done on the alu_delay-th start cycle unless alu_never is set.
    int          alu_cnt;
    int          alu_delay;
    logic        alu_never;
    logic        stale_done;
    logic [15:0] alu_res;

    always @(posedge clk) begin
        if (!bus.alu_start_o) alu_cnt <= 0;
        else                  alu_cnt <= alu_cnt + 1;
    end

    always_comb begin
        case (bus.alu_opcode_o)
            3'd1:    alu_res = 16'(bus.alu_a_o) + 16'(bus.alu_b_o);
            3'd3:    alu_res = 16'(bus.alu_a_o) * 16'(bus.alu_b_o);
            default: alu_res = 16'(bus.alu_a_o ^ bus.alu_b_o);
        endcase
    end

    assign bus.alu_result_i = alu_res;
    assign bus.alu_done_i   = stale_done |
                              (bus.alu_start_o & ~alu_never & (alu_cnt == alu_delay - 1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge after the transfer.
    task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
        bus.req_valid_i       = '0;
        bus.req_valid_i[idx]  = 1'b1;
        bus.req_a_i[idx]      = a;
        bus.req_b_i[idx]      = b;
        bus.req_opcode_i[idx] = op;
        #1;
        chk("ready_onehot", 32'(bus.req_ready_o), 32'(4'b1 << idx));
        @(negedge clk);
        bus.req_valid_i = '0;
    endtask

    // Waits for a response pulse, counting start cycles and operand drift on the way.
    task automatic wait_rsp(input logic [7:0] ea, input logic [7:0] eb,
                            output int starts, output int bad_ops);
        logic seen;
        seen    = 1'b0;
        starts  = 0;
        bad_ops = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rsp_valid_o != '0) begin
                seen = 1'b1;
                break;
            end
            if (bus.alu_start_o) begin
                starts++;
                if (bus.alu_a_o !== ea || bus.alu_b_o !== eb) bad_ops++;
            end
            @(negedge clk);
        end
        chk("rsp_seen", 32'(seen), 32'd1);
    endtask

    int starts;
    int bad_ops;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk           = 0;
        n_err           = 0;
        rst             = 1'b1;
        alu_delay       = 1;
        alu_never       = 1'b0;
        stale_done      = 1'b0;
        bus.req_valid_i = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.req_opcode_i = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_start",     32'(bus.alu_start_o), 32'd0);
        chk("rst_busy",      32'(bus.busy_o),      32'd0);
        chk("rst_result",    32'(bus.rsp_result_o), 32'd0);
        chk("rst_err",       32'(bus.rsp_err_o),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single add request from requester 2
        issue(2, 8'h0F, 8'h03, 3'd1);
        chk("single_start", 32'(bus.alu_start_o), 32'd1);
        chk("single_busy",  32'(bus.busy_o),      32'd1);
        chk("single_op",    32'(bus.alu_opcode_o), 32'd1);
        wait_rsp(8'h0F, 8'h03, starts, bad_ops);
        chk("single_starts", 32'(starts),           32'd1);
        chk("single_vld",    32'(bus.rsp_valid_o),  32'h4);
        chk("single_res",    32'(bus.rsp_result_o), 32'h0012);
        chk("single_err",    32'(bus.rsp_err_o),    32'd0);
        chk("single_start0", 32'(bus.alu_start_o),  32'd0);
        @(negedge clk);
        chk("single_pulse1", 32'(bus.rsp_valid_o),  32'd0);
        chk("single_hold",   32'(bus.rsp_result_o), 32'h0012);
        chk("single_idle",   32'(bus.busy_o),       32'd0);

        // fairness: all four valid from reset
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.req_a_i[k]      = 8'(16 * (k + 1));
            bus.req_b_i[k]      = 8'(k);
            bus.req_opcode_i[k] = 3'd1;
        end
        bus.req_valid_i = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("fair_first_ready", 32'(bus.req_ready_o), 32'h1);
        for (int n = 0; n < 5; n++) begin
            wait_rsp(8'(16 * ((n % 4) + 1)), 8'(n % 4), starts, bad_ops);
            chk("fair_vld", 32'(bus.rsp_valid_o),  32'(4'b1 << (n % 4)));
            chk("fair_res", 32'(bus.rsp_result_o), 32'(16 * ((n % 4) + 1) + (n % 4)));
            if (n == 4) bus.req_valid_i = '0;
            @(negedge clk);
        end

        // no-op from requester 1: no ALU start, response next cycle
        issue(1, 8'hAB, 8'hCD, 3'd0);
        chk("noop_vld",   32'(bus.rsp_valid_o),  32'h2);
        chk("noop_res",   32'(bus.rsp_result_o), 32'd0);
        chk("noop_err",   32'(bus.rsp_err_o),    32'd0);
        chk("noop_start", 32'(bus.alu_start_o),  32'd0);
        chk("noop_busy",  32'(bus.busy_o),       32'd1);
        @(negedge clk);
        chk("noop_pulse1", 32'(bus.rsp_valid_o), 32'd0);
        chk("noop_start1", 32'(bus.alu_start_o), 32'd0);

        // done arriving on the 16th BUSY cycle beats the timeout
        alu_delay = 16;
        issue(0, 8'h12, 8'h34, 3'd3);
        wait_rsp(8'h12, 8'h34, starts, bad_ops);
        chk("tie_starts", 32'(starts),           32'd16);
        chk("tie_vld",    32'(bus.rsp_valid_o),  32'h1);
        chk("tie_err",    32'(bus.rsp_err_o),    32'd0);
        chk("tie_res",    32'(bus.rsp_result_o), 32'h03A8);
        @(negedge clk);

        // reset during BUSY cycle 2 of a mul, then a stale done
        alu_never = 1'b1;
        issue(2, 8'h05, 8'h07, 3'd3);
        chk("rmid_start", 32'(bus.alu_start_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmid_start0", 32'(bus.alu_start_o), 32'd0);
        chk("rmid_busy0",  32'(bus.busy_o),      32'd0);
        chk("rmid_vld0",   32'(bus.rsp_valid_o), 32'd0);
        stale_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stale_vld",  32'(bus.rsp_valid_o), 32'd0);
            chk("stale_busy", 32'(bus.busy_o),      32'd0);
        end
        stale_done = 1'b0;
        bus.req_valid_i = 4'hF;
        #1;
        chk("rmid_rr0", 32'(bus.req_ready_o), 32'h1);
        bus.req_valid_i = '0;
        @(negedge clk);

        // timeout: ALU never answers
        issue(1, 8'hAA, 8'h55, 3'd2);
        wait_rsp(8'hAA, 8'h55, starts, bad_ops);
        chk("tmo_starts",  32'(starts),           32'd16);
        chk("tmo_opsheld", 32'(bad_ops),          32'd0);
        chk("tmo_vld",     32'(bus.rsp_valid_o),  32'h2);
        chk("tmo_err",     32'(bus.rsp_err_o),    32'd1);
        chk("tmo_res",     32'(bus.rsp_result_o), 32'd0);
        @(negedge clk);
        chk("tmo_err_hold", 32'(bus.rsp_err_o), 32'd1);
        bus.req_valid_i = 4'hF;
        #1;
        chk("tmo_rr_adv", 32'(bus.req_ready_o), 32'h4);
        bus.req_valid_i = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
